lcd_power_sequencer: RTL and testbench
======================================

Name: lcd_power_sequencer

Overview:
Sequences power-up and power-down of the 400x272 RGB TFT panel. It gates the pixel-clock divider, holds the timing generator in reset, and counts frames before asserting display-on. It then ramps the backlight PWM up or down. It sits in TOP between the 24 MHz XTAL clock domain, the KEY input, the VGAMod timing generator and the panel DISP/backlight pins.

Parameters:
CLK_WAIT_CYC, 2400000, cycles from PCLK_EN rising to TIMING_nRST release (100 ms at 24 MHz)
FRAMES_ON, 2, frame ticks between TIMING_nRST release and DISP_ON rising
FRAMES_OFF, 2, frame ticks between DISP_ON falling and PCLK_EN falling
RAMP_STEP_CYC, 24000, cycles per one-LSB backlight level change
BL_MAX, 255, backlight target level (8-bit)
DEB_CYC, 240000, KEY stable-low cycles required to register a press
FRAME_TIMEOUT, 4800000, max cycles waiting for one frame tick before FAULT
AUTO_ON, 1, 1 = start power-up automatically after reset

Ports:
CLK  in  1  system clock (XTAL_IN, 24 MHz)
nRST  in  1  asynchronous active-low reset
KEY  in  1  raw push button, active-low, asynchronous to CLK
FRAME_TICK  in  1  one-cycle pulse per frame from timing generator, CLK domain
PCLK_EN  out  1  enables pixel-clock divider
TIMING_nRST  out  1  active-low reset for timing generator
DISP_ON  out  1  panel display enable
BL_PWM  out  1  backlight PWM
BL_LEVEL  out  8  current backlight level
STATE  out  3  current FSM state encoding
READY  out  1  high only in ON

Behaviour:
- Reset (async, nRST low): every output is 0, TIMING_nRST=0, BL_LEVEL=0, STATE=OFF. All counters clear. The FSM holds while nRST is low and restarts from OFF on release.
- KEY: 2-flop synchronizer, then debounce counter. A press event is a 1-cycle pulse generated once per stable-low period of DEB_CYC cycles. A release needs no debounce before the next press can count.
- State encoding: OFF=0, CLK_WAIT=1, FRAME_WAIT=2, RAMP_UP=3, ON=4, RAMP_DOWN=5, DISP_OFF_WAIT=6, FAULT=7.
- OFF: all outputs low. Go to CLK_WAIT on a press, or on the first cycle after reset if AUTO_ON=1.
- CLK_WAIT: PCLK_EN=1. After CLK_WAIT_CYC cycles, go to FRAME_WAIT.
- FRAME_WAIT: TIMING_nRST=1. Count FRAME_TICK pulses. On the FRAMES_ON-th tick, go to RAMP_UP with DISP_ON=1 from the next cycle. If no tick arrives within FRAME_TIMEOUT cycles of the last tick or state entry, go to FAULT.
- RAMP_UP: BL_LEVEL increments by 1 every RAMP_STEP_CYC cycles. Reaching BL_MAX goes to ON. A press goes to RAMP_DOWN from the current level.
- ON: READY=1, BL_LEVEL=BL_MAX. A press goes to RAMP_DOWN.
- RAMP_DOWN: BL_LEVEL decrements by 1 every RAMP_STEP_CYC cycles. Reaching 0 goes to DISP_OFF_WAIT with DISP_ON=0. Presses are ignored.
- DISP_OFF_WAIT: TIMING_nRST and PCLK_EN stay 1. On the FRAMES_OFF-th tick, go to OFF. The same FRAME_TIMEOUT rule applies, but a timeout here goes to OFF, not FAULT.
- FAULT: PCLK_EN=1 and TIMING_nRST=0; all other outputs 0. A press goes to OFF.
- Presses in CLK_WAIT and FRAME_WAIT are ignored, not latched.
- The step counter is cleared on every state entry, so the first step occurs RAMP_STEP_CYC cycles after entry.
- BL_LEVEL is clamped within 0..BL_MAX and never wraps.
- PWM: an 8-bit free-running counter. BL_PWM is registered as (cnt < BL_LEVEL), giving duty BL_LEVEL/256 with one cycle of latency. BL_LEVEL=0 gives a constant 0.
- Simultaneous FRAME_TICK and a timeout expiry: the tick wins.
- Simultaneous press and ramp completion: the ramp completion transition wins, and the press is dropped.
- All outputs are registered.

Test Plan:
1. Sim parameters: CLK_WAIT_CYC=10, FRAMES_ON=2, FRAMES_OFF=2, RAMP_STEP_CYC=4, BL_MAX=8, DEB_CYC=3, FRAME_TIMEOUT=50, AUTO_ON=1. Release reset, tick every 20 cycles.
   -> PCLK_EN=1 at cycle 1, TIMING_nRST=1 at cycle 11, DISP_ON=1 one cycle after the 2nd tick.
   -> BL_LEVEL reaches 8 after 32 cycles in RAMP_UP, then READY=1 and STATE=4.
2. From ON, hold KEY low for 5 cycles.
   -> Exactly one press is registered.
   -> BL_LEVEL falls 8 to 0 over 32 cycles, DISP_ON=0, PCLK_EN=0 after 2 more ticks, STATE=0.
3. Press while BL_LEVEL=3 in RAMP_UP.
   -> RAMP_DOWN starts at 3, with no increment to 4 after the press.
4. Stop FRAME_TICK in FRAME_WAIT.
   -> STATE=7 after 50 cycles, DISP_ON=0, TIMING_nRST=0.
   -> A press then gives STATE=0.
5. Drive KEY with 1-cycle low glitches.
   -> No state change.
6. Assert nRST mid-RAMP_UP with BL_LEVEL=5.
   -> All outputs 0 in the same cycle (asynchronous).
   -> After release, the full sequence repeats from OFF.
7. BL_LEVEL=2 with 8-bit PWM.
   -> BL_PWM is high for 2 of every 256 cycles.

Source files
------------

// File: rtl/lcd_power_sequencer_if.sv
// Panel power-sequencer signal bundle: button and frame tick in,
// panel enables, backlight and status out.
interface lcd_power_sequencer_if;
    logic       KEY;
    logic       FRAME_TICK;
    logic       PCLK_EN;
    logic       TIMING_nRST;
    logic       DISP_ON;
    logic       BL_PWM;
    logic [7:0] BL_LEVEL;
    logic [2:0] STATE;
    logic       READY;

    // Board / top-level side: drives the button and frame tick.
    modport master (
        output KEY, FRAME_TICK,
        input  PCLK_EN, TIMING_nRST, DISP_ON, BL_PWM, BL_LEVEL, STATE, READY
    );

    // Sequencer side.
    modport slave (
        input  KEY, FRAME_TICK,
        output PCLK_EN, TIMING_nRST, DISP_ON, BL_PWM, BL_LEVEL, STATE, READY
    );
endinterface

// File: rtl/lcd_power_sequencer.sv
// Power-up / power-down sequencer for the RGB TFT panel: pixel clock,
// timing-generator reset, display enable and backlight ramp with PWM.
module lcd_power_sequencer #(
    parameter int CLK_WAIT_CYC  = 2400000,
    parameter int FRAMES_ON     = 2,
    parameter int FRAMES_OFF    = 2,
    parameter int RAMP_STEP_CYC = 24000,
    parameter int BL_MAX        = 255,
    parameter int DEB_CYC       = 240000,
    parameter int FRAME_TIMEOUT = 4800000,
    parameter int AUTO_ON       = 1
) (
    input logic                 CLK,
    input logic                 nRST,
    lcd_power_sequencer_if.slave bus
);
    // One shared cycle counter serves the clock wait, ramp steps and frame timeout.
    localparam int CMAX0 = (CLK_WAIT_CYC > FRAME_TIMEOUT) ? CLK_WAIT_CYC : FRAME_TIMEOUT;
    localparam int CMAX  = (CMAX0 > RAMP_STEP_CYC) ? CMAX0 : RAMP_STEP_CYC;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int DW    = $clog2(DEB_CYC + 1);

    localparam logic [CW-1:0] CLK_WAIT_M1 = CW'(CLK_WAIT_CYC - 1);
    localparam logic [CW-1:0] STEP_M1     = CW'(RAMP_STEP_CYC - 1);
    localparam logic [CW-1:0] TO_M1       = CW'(FRAME_TIMEOUT - 1);
    localparam logic [DW-1:0] DEB_M1      = DW'(DEB_CYC - 1);
    localparam logic [DW-1:0] DEB_SAT     = DW'(DEB_CYC);
    localparam logic [7:0]    FON_M1      = 8'(FRAMES_ON - 1);
    localparam logic [7:0]    FOFF_M1     = 8'(FRAMES_OFF - 1);
    localparam logic [7:0]    BLM         = 8'(BL_MAX);

    typedef enum logic [2:0] {
        S_OFF           = 3'd0,
        S_CLK_WAIT      = 3'd1,
        S_FRAME_WAIT    = 3'd2,
        S_RAMP_UP       = 3'd3,
        S_ON            = 3'd4,
        S_RAMP_DOWN     = 3'd5,
        S_DISP_OFF_WAIT = 3'd6,
        S_FAULT         = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tick_q, tick_d;
    logic [7:0]    level_q, level_d;
    logic          auto_q;
    logic          key_s1_q, key_s2_q;
    logic [DW-1:0] deb_q;
    logic          press, step_end;
    logic [7:0]    pwm_cnt_q;
    logic          pwm_q;
    logic          pclk_en_q, pclk_en_d;
    logic          tnrst_q, tnrst_d;
    logic          disp_on_q, disp_on_d;
    logic          ready_q, ready_d;

    // Synchronise KEY and count stable-low cycles; saturation keeps it to one press per hold.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            deb_q    <= '0;
        end else begin
            key_s1_q <= bus.KEY;
            key_s2_q <= key_s1_q;
            if (key_s2_q)             deb_q <= '0;
            else if (deb_q != DEB_SAT) deb_q <= deb_q + 1'b1;
        end
    end

    assign press = !key_s2_q && (deb_q == DEB_M1);

    // Free-running PWM counter and registered compare against the current level.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            pwm_q     <= (pwm_cnt_q < level_q);
        end
    end

    // State, counters, backlight level and registered panel controls.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            tick_q    <= '0;
            level_q   <= '0;
            auto_q    <= (AUTO_ON != 0);
            pclk_en_q <= 1'b0;
            tnrst_q   <= 1'b0;
            disp_on_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
            auto_q    <= 1'b0;
            pclk_en_q <= pclk_en_d;
            tnrst_q   <= tnrst_d;
            disp_on_q <= disp_on_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they land with it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        tick_d   = tick_q;
        level_d  = level_q;
        step_end = (cnt_q == STEP_M1);
        case (state_q)
            S_OFF:      if (press || auto_q) state_d = S_CLK_WAIT;
            S_CLK_WAIT: if (cnt_q == CLK_WAIT_M1) state_d = S_FRAME_WAIT;
            S_FRAME_WAIT: begin
                // A tick in the same cycle as the timeout expiry takes precedence.
                if (bus.FRAME_TICK) begin
                    cnt_d  = '0;
                    tick_d = tick_q + 8'd1;
                    if (tick_q == FON_M1) state_d = S_RAMP_UP;
                end else if (cnt_q == TO_M1) begin
                    state_d = S_FAULT;
                end
            end
            S_RAMP_UP: begin
                // Completing the ramp beats a coincident press; a press otherwise
                // freezes the level and reverses from there.
                if (step_end && ({1'b0, level_q} + 9'd1 >= {1'b0, BLM})) begin
                    level_d = BLM;
                    state_d = S_ON;
                end else if (press) begin
                    state_d = S_RAMP_DOWN;
                end else if (step_end) begin
                    level_d = level_q + 8'd1;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                level_d = BLM;
                if (press) state_d = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
                if (step_end) begin
                    cnt_d = '0;
                    if (level_q <= 8'd1) begin
                        level_d = '0;
                        state_d = S_DISP_OFF_WAIT;
                    end else begin
                        level_d = level_q - 8'd1;
                    end
                end
            end
            S_DISP_OFF_WAIT: begin
                if (bus.FRAME_TICK) begin
                    cnt_d  = '0;
                    tick_d = tick_q + 8'd1;
                    if (tick_q == FOFF_M1) state_d = S_OFF;
                end else if (cnt_q == TO_M1) begin
                    state_d = S_OFF;
                end
            end
            S_FAULT:    if (press) state_d = S_OFF;
            default:    state_d = S_OFF;
        endcase
        if (state_d != state_q) begin
            cnt_d  = '0;
            tick_d = '0;
        end
        if (state_d inside {S_OFF, S_CLK_WAIT, S_FRAME_WAIT, S_FAULT}) level_d = '0;

        pclk_en_d = (state_d != S_OFF);
        tnrst_d   = state_d inside {S_FRAME_WAIT, S_RAMP_UP, S_ON, S_RAMP_DOWN, S_DISP_OFF_WAIT};
        disp_on_d = state_d inside {S_RAMP_UP, S_ON, S_RAMP_DOWN};
        ready_d   = (state_d == S_ON);
    end

    assign bus.PCLK_EN     = pclk_en_q;
    assign bus.TIMING_nRST = tnrst_q;
    assign bus.DISP_ON     = disp_on_q;
    assign bus.BL_PWM      = pwm_q;
    assign bus.BL_LEVEL    = level_q;
    assign bus.STATE       = state_q;
    assign bus.READY       = ready_q;
endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Directed bench for lcd_power_sequencer with short sim timing; a second
// instance with BL_MAX=2 exercises a low PWM duty.
module tb_lcd_power_sequencer;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 CLK = ~CLK;

    lcd_power_sequencer_if u_if ();
    lcd_power_sequencer_if u_if2 ();

    assign u_if2.KEY        = 1'b1;
    assign u_if2.FRAME_TICK = u_if.FRAME_TICK;

    lcd_power_sequencer #(
        .CLK_WAIT_CYC(10), .FRAMES_ON(2), .FRAMES_OFF(2), .RAMP_STEP_CYC(4),
        .BL_MAX(8), .DEB_CYC(3), .FRAME_TIMEOUT(50), .AUTO_ON(1)
    ) u_dut (.CLK(CLK), .nRST(nRST), .bus(u_if.slave));

    lcd_power_sequencer #(
        .CLK_WAIT_CYC(10), .FRAMES_ON(2), .FRAMES_OFF(2), .RAMP_STEP_CYC(4),
        .BL_MAX(2), .DEB_CYC(3), .FRAME_TIMEOUT(50), .AUTO_ON(1)
    ) u_dut2 (.CLK(CLK), .nRST(nRST), .bus(u_if2.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_tick();
        u_if.FRAME_TICK = 1'b1;
        step(1);
        u_if.FRAME_TICK = 1'b0;
    endtask

    task automatic press(input int n);
        u_if.KEY = 1'b0;
        step(n);
        u_if.KEY = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (u_if.STATE !== s && n < budget) begin
            step(1);
            n++;
        end
        chk("wait_state", 32'(u_if.STATE), 32'(s));
    endtask

    // From CLK_WAIT: two ticks 5 cycles apart land the DUT in RAMP_UP.
    task automatic bring_up();
        wait_state(3'd2, 40);
        step(5);
        pulse_tick();
        step(5);
        pulse_tick();
        chk("bringup_state", 32'(u_if.STATE), 32'd3);
        chk("bringup_disp", 32'(u_if.DISP_ON), 32'd1);
    endtask

    initial begin
        int hi1, hi2;
        u_if.KEY = 1'b1;
        u_if.FRAME_TICK = 1'b0;

        // Reset values
        step(1);
        chk("rst_state", 32'(u_if.STATE), 32'd0);
        chk("rst_pclk", 32'(u_if.PCLK_EN), 32'd0);
        chk("rst_tnrst", 32'(u_if.TIMING_nRST), 32'd0);
        chk("rst_level", 32'(u_if.BL_LEVEL), 32'd0);
        nRST = 1'b1;

        // 1: auto power-up timeline (cycle numbers since reset release)
        step(1);
        chk("c1_pclk", 32'(u_if.PCLK_EN), 32'd1);
        chk("c1_state", 32'(u_if.STATE), 32'd1);
        step(9);
        chk("c10_tnrst", 32'(u_if.TIMING_nRST), 32'd0);
        step(1);
        chk("c11_tnrst", 32'(u_if.TIMING_nRST), 32'd1);
        chk("c11_state", 32'(u_if.STATE), 32'd2);
        step(8);
        pulse_tick();
        step(19);
        chk("c39_disp", 32'(u_if.DISP_ON), 32'd0);
        pulse_tick();
        chk("c40_disp", 32'(u_if.DISP_ON), 32'd1);
        chk("c40_state", 32'(u_if.STATE), 32'd3);
        step(31);
        chk("c71_level", 32'(u_if.BL_LEVEL), 32'd7);
        chk("c71_ready", 32'(u_if.READY), 32'd0);
        step(1);
        chk("c72_level", 32'(u_if.BL_LEVEL), 32'd8);
        chk("c72_state", 32'(u_if.STATE), 32'd4);
        chk("c72_ready", 32'(u_if.READY), 32'd1);

        // 7: PWM duty over 256 cycles, level 8 on DUT1 and level 2 on DUT2
        hi1 = 0;
        hi2 = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            hi1 += int'(u_if.BL_PWM);
            hi2 += int'(u_if2.BL_PWM);
        end
        chk("pwm8_count", 32'(hi1), 32'd8);
        chk("pwm2_count", 32'(hi2), 32'd2);
        chk("dut2_level", 32'(u_if2.BL_LEVEL), 32'd2);

        // 2: 5-cycle press from ON, ramp down, two ticks to OFF
        press(5);
        chk("pd_state", 32'(u_if.STATE), 32'd5);
        chk("pd_level0", 32'(u_if.BL_LEVEL), 32'd8);
        step(31);
        chk("pd_level31", 32'(u_if.BL_LEVEL), 32'd1);
        chk("pd_disp31", 32'(u_if.DISP_ON), 32'd1);
        step(1);
        chk("pd_level32", 32'(u_if.BL_LEVEL), 32'd0);
        chk("pd_state32", 32'(u_if.STATE), 32'd6);
        chk("pd_disp32", 32'(u_if.DISP_ON), 32'd0);
        chk("pd_pclk32", 32'(u_if.PCLK_EN), 32'd1);
        step(5);
        pulse_tick();
        chk("pd_tick1", 32'(u_if.STATE), 32'd6);
        step(5);
        pulse_tick();
        chk("pd_off_state", 32'(u_if.STATE), 32'd0);
        chk("pd_off_pclk", 32'(u_if.PCLK_EN), 32'd0);
        chk("pd_off_tnrst", 32'(u_if.TIMING_nRST), 32'd0);
        step(5);
        chk("pd_stay_off", 32'(u_if.STATE), 32'd0);

        // 5: 1- and 2-cycle KEY glitches in OFF
        for (int i = 0; i < 3; i++) begin
            press(1);
            step(4);
        end
        press(2);
        step(5);
        chk("glitch_state", 32'(u_if.STATE), 32'd0);

        // 3: press while level 3 in RAMP_UP
        press(5);
        chk("p3_clkwait", 32'(u_if.STATE), 32'd1);
        bring_up();
        step(9);
        press(5);
        chk("p3_state", 32'(u_if.STATE), 32'd5);
        chk("p3_level", 32'(u_if.BL_LEVEL), 32'd3);
        step(2);
        chk("p3_no_inc", 32'(u_if.BL_LEVEL), 32'd3);
        step(2);
        chk("p3_dec", 32'(u_if.BL_LEVEL), 32'd2);
        wait_state(3'd6, 40);
        step(3);
        pulse_tick();
        step(3);
        pulse_tick();
        chk("p3_off", 32'(u_if.STATE), 32'd0);

        // 4: tick on the timeout cycle wins, then a missing tick faults
        press(5);
        wait_state(3'd2, 40);
        step(49);
        pulse_tick();
        chk("to_tick_wins", 32'(u_if.STATE), 32'd2);
        step(49);
        chk("to_before", 32'(u_if.STATE), 32'd2);
        step(1);
        chk("to_fault", 32'(u_if.STATE), 32'd7);
        chk("to_tnrst", 32'(u_if.TIMING_nRST), 32'd0);
        chk("to_disp", 32'(u_if.DISP_ON), 32'd0);
        chk("to_pclk", 32'(u_if.PCLK_EN), 32'd1);
        press(12);
        step(3);
        chk("fault_to_off", 32'(u_if.STATE), 32'd0);
        step(10);
        chk("one_press", 32'(u_if.STATE), 32'd0);

        // 6: async reset mid-ramp at level 5, then full restart
        press(5);
        bring_up();
        step(20);
        chk("r6_level5", 32'(u_if.BL_LEVEL), 32'd5);
        nRST = 1'b0;
        #1;
        chk("r6_state", 32'(u_if.STATE), 32'd0);
        chk("r6_level", 32'(u_if.BL_LEVEL), 32'd0);
        chk("r6_disp", 32'(u_if.DISP_ON), 32'd0);
        chk("r6_pclk", 32'(u_if.PCLK_EN), 32'd0);
        chk("r6_tnrst", 32'(u_if.TIMING_nRST), 32'd0);
        chk("r6_pwm", 32'(u_if.BL_PWM), 32'd0);
        step(3);
        nRST = 1'b1;
        step(1);
        chk("r6_restart", 32'(u_if.STATE), 32'd1);
        bring_up();
        wait_state(3'd4, 40);
        chk("r6_on_level", 32'(u_if.BL_LEVEL), 32'd8);
        chk("r6_on_ready", 32'(u_if.READY), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
